// File: rtl/picorv32_pcpi_issuer_pkg.sv
// Shared PCPI definitions: issuer FSM states, custom-0 opcode, FP funct7 codes
// and default timing limits.
package pcpi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [6:0] PCPI_CUSTOM0 = 7'b0001011;

  localparam logic [6:0] FPADD = 7'b0000001;
  localparam logic [6:0] FPSUB = 7'b0000010;
  localparam logic [6:0] FPMUL = 7'b0000011;
  localparam logic [6:0] FPDIV = 7'b0000100;

  localparam int unsigned DEF_TIMEOUT      = 16;
  localparam int unsigned DEF_LONG_TIMEOUT = 1024;
  localparam int unsigned DEF_GAP          = 1;

  // Assemble an R-type custom-0 instruction word.
  function automatic logic [31:0] make_rtype(input logic [6:0] funct7,
                                             input logic [4:0] rs2,
                                             input logic [4:0] rs1,
                                             input logic [4:0] rd);
    return {funct7, rs2, rs1, 3'b000, rd, PCPI_CUSTOM0};
  endfunction

endpackage

// File: rtl/picorv32_pcpi_issuer_sat_counter.sv
// Saturating counter with synchronous load and count enable; counts up to all
// ones or, with DOWN set, down to zero.
module pcpi_sat_counter #(
  parameter int unsigned WIDTH = 16,
  parameter bit          DOWN  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_d,
  output logic [WIDTH-1:0] count_q
);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (DOWN) begin
        if (count_q != '0) count_d = count_q - 1'b1;
      end else begin
        if (count_q != '1) count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/picorv32_pcpi_issuer.sv
// PCPI initiator: issues one command at a time to a PCPI responder, handles
// pcpi_wait and timeouts, and returns result/error/latency on a response stream.
module picorv32_pcpi_issuer
  import pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter int unsigned LONG_TIMEOUT = DEF_LONG_TIMEOUT,
  parameter int unsigned GAP          = DEF_GAP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_wr,
  output logic        rsp_err,
  output logic [15:0] rsp_cycles
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [15:0] LONG_C    = 16'(LONG_TIMEOUT);
  localparam logic [15:0] GAP_C     = 16'(GAP);

  state_t      state_q, state_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic        pcpi_valid_q, pcpi_valid_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_wr_q, rsp_wr_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] rsp_cycles_q, rsp_cycles_d;
  logic        seen_wait_q, seen_wait_d;
  logic        issue_timeout;

  logic        cnt_load, cnt_en;
  logic [15:0] cnt_q, cnt_next_unused;
  logic        gap_load, gap_en;
  logic [15:0] gap_q, gap_d;

  pcpi_sat_counter #(.WIDTH(16), .DOWN(1'b0)) u_cycle_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (16'd1),
    .count_d  (cnt_next_unused),
    .count_q  (cnt_q)
  );

  pcpi_sat_counter #(.WIDTH(16), .DOWN(1'b1)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .en       (gap_en),
    .load_val (GAP_C),
    .count_d  (gap_d),
    .count_q  (gap_q)
  );

  always_comb begin
    state_d       = state_q;
    insn_d        = insn_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rsp_data_d    = rsp_data_q;
    rsp_wr_d      = rsp_wr_q;
    rsp_err_d     = rsp_err_q;
    rsp_cycles_d  = rsp_cycles_q;
    seen_wait_d   = seen_wait_q;
    issue_timeout = 1'b0;
    cnt_load      = 1'b0;
    cnt_en        = (state_q == ISSUE);
    gap_load      = 1'b0;
    gap_en        = (state_q == IDLE);

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          insn_d      = cmd_insn;
          rs1_d       = cmd_rs1;
          rs2_d       = cmd_rs2;
          seen_wait_d = 1'b0;
          cnt_load    = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // A wait arriving in the last short-window cycle still extends the window.
        seen_wait_d   = seen_wait_q | pcpi_wait;
        issue_timeout = seen_wait_d ? (cnt_q == LONG_C) : (cnt_q == TIMEOUT_C);
        if (pcpi_ready) begin
          rsp_data_d   = pcpi_rd;
          rsp_wr_d     = pcpi_wr;
          rsp_err_d    = 1'b0;
          rsp_cycles_d = cnt_q;
          state_d      = RESP;
        end else if (issue_timeout) begin
          rsp_data_d   = '0;
          rsp_wr_d     = 1'b0;
          rsp_err_d    = 1'b1;
          rsp_cycles_d = cnt_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          gap_load = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pcpi_valid_d = (state_d == ISSUE);
    rsp_valid_d  = (state_d == RESP);
  end

  // Kept apart from the main block: gap_d depends on gap_load computed above.
  always_comb begin
    cmd_ready_d = (state_d == IDLE) && (gap_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      insn_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      pcpi_valid_q <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_wr_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_cycles_q <= '0;
      seen_wait_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      insn_q       <= insn_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      pcpi_valid_q <= pcpi_valid_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_err_q    <= rsp_err_d;
      rsp_cycles_q <= rsp_cycles_d;
      seen_wait_q  <= seen_wait_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign pcpi_valid = pcpi_valid_q;
  assign pcpi_insn  = insn_q;
  assign pcpi_rs1   = rs1_q;
  assign pcpi_rs2   = rs2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_wr     = rsp_wr_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_cycles = rsp_cycles_q;

endmodule

// File: tb/tb_picorv32_pcpi_issuer.sv
// Bench for picorv32_pcpi_issuer: a scripted PCPI responder plus a timing
// model of when each command completes or times out.
module tb_picorv32_pcpi_issuer;
  import pcpi_pkg::*;

  localparam int unsigned TB_TIMEOUT = 16;
  localparam int unsigned TB_LONG    = 1024;
  localparam int unsigned TB_GAP     = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_insn = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wait = 1'b0, pcpi_ready = 1'b0, pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_wr, rsp_err;
  logic [15:0] rsp_cycles;

  always #5 clk = ~clk;

  picorv32_pcpi_issuer #(
    .TIMEOUT      (TB_TIMEOUT),
    .LONG_TIMEOUT (TB_LONG),
    .GAP          (TB_GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_insn   (cmd_insn),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_wr     (rsp_wr),
    .rsp_err    (rsp_err),
    .rsp_cycles (rsp_cycles)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Responder result: exact FPSUB (rs2 - rs1) for the tabled operand pairs,
  // an arbitrary mixing function for everything else.
  function automatic logic [31:0] resp_func(input logic [31:0] insn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] sw;
    if (insn[6:0] == PCPI_CUSTOM0 && insn[31:25] == FPSUB) begin
      if (a == 32'h40000000 && b == 32'h40400000) return 32'h3F800000;
      if (a == 32'h3F800000 && b == 32'h40400000) return 32'h40000000;
    end
    sw = {insn[15:0], insn[31:16]};
    return (a + b) ^ sw;
  endfunction

  // Outcome of a command whose responder raises wait from cycle wait_at and
  // ready at cycle rdy_at (0 = never), cycles counted from pcpi_valid rise.
  function automatic void model(input int unsigned rdy_at, input int unsigned wait_at,
                                output logic err, output logic [15:0] cyc);
    bit          waited;
    int unsigned limit;
    waited = (wait_at != 0) && (wait_at <= TB_TIMEOUT) && (rdy_at == 0 || wait_at < rdy_at);
    limit  = waited ? TB_LONG : TB_TIMEOUT;
    if (rdy_at != 0 && rdy_at <= limit) begin
      err = 1'b0;
      cyc = 16'(rdy_at);
    end else begin
      err = 1'b1;
      cyc = 16'(limit);
    end
  endfunction

  // Scripted responder, driven on the falling edge.
  int unsigned r_rdy_at = 0, r_rdy_len = 1, r_wait_at = 0;
  logic        r_wr = 1'b1;
  int unsigned rk = 0;
  logic        rk_prev = 1'b0;

  always @(negedge clk) begin
    if (pcpi_valid === 1'b1 && !rk_prev) rk = 1;
    else if (rk != 0 && rk < 100000) rk = rk + 1;
    rk_prev    = (pcpi_valid === 1'b1);
    pcpi_ready = (r_rdy_at != 0) && (rk >= r_rdy_at) && (rk < r_rdy_at + r_rdy_len);
    pcpi_wait  = (r_wait_at != 0) && (rk >= r_wait_at) && !pcpi_ready && (pcpi_valid === 1'b1);
    pcpi_rd    = pcpi_ready ? resp_func(pcpi_insn, pcpi_rs1, pcpi_rs2) : $urandom;
    pcpi_wr    = pcpi_ready ? r_wr : 1'($urandom);
  end

  // Bus monitor: operand stability, idle gap between requests, response count.
  int unsigned op_changes = 0, gap_viol = 0, rsp_rises = 0, low_run = 0;
  logic        mon_pv = 1'b0, mon_rv = 1'b0, mon_seen = 1'b0;
  logic [31:0] mon_insn = '0, mon_rs1 = '0, mon_rs2 = '0;

  always @(negedge clk) begin
    if (pcpi_valid === 1'b1) begin
      if (mon_pv && (pcpi_insn !== mon_insn || pcpi_rs1 !== mon_rs1 || pcpi_rs2 !== mon_rs2))
        op_changes = op_changes + 1;
      if (!mon_pv && mon_seen && low_run < TB_GAP) gap_viol = gap_viol + 1;
      mon_seen = 1'b1;
      low_run  = 0;
    end else begin
      low_run = low_run + 1;
    end
    mon_pv   = (pcpi_valid === 1'b1);
    mon_insn = pcpi_insn;
    mon_rs1  = pcpi_rs1;
    mon_rs2  = pcpi_rs2;
    if (rsp_valid === 1'b1 && !mon_rv) rsp_rises = rsp_rises + 1;
    mon_rv = (rsp_valid === 1'b1);
  end

  typedef struct {
    bit          accepted;
    bit          got_rsp;
    logic [31:0] data;
    logic        wr;
    logic        err;
    logic [15:0] cycles;
    int unsigned valid_cycles;
    logic        pv_after_accept;
    logic        pv_in_resp;
    bit          unstable;
    bit          cmdrdy_in_resp;
    int unsigned ready_delay;
  } obs_t;

  // Drives one command and its response handshake; called and returns on a
  // falling edge. Collects observations only.
  task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                         input int unsigned rdy_at, input int unsigned rdy_len,
                         input int unsigned wait_at, input logic wr, input int unsigned hold,
                         input bit keep_valid, output obs_t o);
    int unsigned n;
    o.accepted = 0; o.got_rsp = 0; o.data = 'x; o.wr = 'x; o.err = 'x; o.cycles = 'x;
    o.valid_cycles = 0; o.pv_after_accept = 'x; o.pv_in_resp = 'x;
    o.unstable = 0; o.cmdrdy_in_resp = 0; o.ready_delay = 0;
    r_rdy_at = rdy_at; r_rdy_len = rdy_len; r_wait_at = wait_at; r_wr = wr;
    cmd_valid = 1'b1; cmd_insn = insn; cmd_rs1 = rs1; cmd_rs2 = rs2;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (cmd_ready !== 1'b1) begin cmd_valid = 1'b0; return; end
    @(negedge clk);
    o.accepted = 1;
    o.pv_after_accept = pcpi_valid;
    if (!keep_valid) cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 2000) begin
      if (pcpi_valid === 1'b1) o.valid_cycles++;
      @(negedge clk);
      n++;
    end
    if (rsp_valid !== 1'b1) return;
    o.got_rsp = 1;
    o.data = rsp_data; o.wr = rsp_wr; o.err = rsp_err; o.cycles = rsp_cycles;
    o.pv_in_resp = pcpi_valid;
    if (cmd_ready !== 1'b0) o.cmdrdy_in_resp = 1;
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== o.data || rsp_wr !== o.wr ||
          rsp_err !== o.err || rsp_cycles !== o.cycles) o.unstable = 1;
      if (cmd_ready !== 1'b0) o.cmdrdy_in_resp = 1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0) o.unstable = 1;
    n = 1;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    o.ready_delay = n;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); end
    checks++; if (pcpi_valid !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valids got=%b%b want=00", pcpi_valid, rsp_valid); end
    checks++; if ({pcpi_insn, pcpi_rs1, pcpi_rs2} !== '0) begin errors++; $display("FAIL reset_operands got=%h %h %h want=0", pcpi_insn, pcpi_rs1, pcpi_rs2); end
    checks++; if ({rsp_data, rsp_wr, rsp_err, rsp_cycles} !== '0) begin errors++; $display("FAIL reset_rsp got=%h %b %b %h want=0", rsp_data, rsp_wr, rsp_err, rsp_cycles); end
    reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_release_early got=%b want=0", cmd_ready); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready_rise got=%b want=1", cmd_ready); end
  endtask

  task automatic test_fpsub();
    obs_t o;
    logic [31:0] insn;
    insn = make_rtype(FPSUB, 5'd2, 5'd1, 5'd3);
    run_txn(insn, 32'h40000000, 32'h40400000, 3, 1, 1, 1'b1, 0, 0, o);
    checks++; if (!o.accepted || !o.got_rsp) begin errors++; $display("FAIL fpsub_handshake got=%0d%0d want=11", o.accepted, o.got_rsp); end
    checks++; if (o.pv_after_accept !== 1'b1) begin errors++; $display("FAIL fpsub_valid_latency got=%b want=1", o.pv_after_accept); end
    checks++; if (o.data !== 32'h3F800000) begin errors++; $display("FAIL fpsub_data got=%h want=3f800000", o.data); end
    checks++; if (o.wr !== 1'b1 || o.err !== 1'b0) begin errors++; $display("FAIL fpsub_flags got=wr%b err%b want=wr1 err0", o.wr, o.err); end
    checks++; if (o.cycles !== 16'd3 || o.valid_cycles != 3) begin errors++; $display("FAIL fpsub_cycles got=%0d (valid %0d) want=3", o.cycles, o.valid_cycles); end
    checks++; if (o.pv_in_resp !== 1'b0) begin errors++; $display("FAIL fpsub_valid_drop got=%b want=0", o.pv_in_resp); end
    checks++; if (o.ready_delay != 1 + TB_GAP) begin errors++; $display("FAIL fpsub_gap got=%0d want=%0d", o.ready_delay, 1 + TB_GAP); end
  endtask

  task automatic test_no_responder();
    obs_t o;
    run_txn(32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 1, 0, 1'b1, 0, 0, o);
    checks++; if (!o.got_rsp || o.err !== 1'b1) begin errors++; $display("FAIL noresp_err got=rsp%0d err%b want=rsp1 err1", o.got_rsp, o.err); end
    checks++; if (o.data !== 32'h0 || o.wr !== 1'b0) begin errors++; $display("FAIL noresp_data got=%h wr%b want=0 wr0", o.data, o.wr); end
    checks++; if (o.cycles !== 16'(TB_TIMEOUT) || o.valid_cycles != TB_TIMEOUT) begin errors++; $display("FAIL noresp_cycles got=%0d (valid %0d) want=%0d", o.cycles, o.valid_cycles, TB_TIMEOUT); end
  endtask

  task automatic test_long_wait();
    obs_t o;
    logic [31:0] insn;
    insn = make_rtype(FPMUL, 5'd7, 5'd6, 5'd5);
    run_txn(insn, 32'h0000_0011, 32'h0000_0022, 40, 1, 3, 1'b1, 0, 0, o);
    checks++; if (!o.got_rsp || o.err !== 1'b0 || o.cycles !== 16'd40) begin errors++; $display("FAIL longwait got=err%b cyc%0d want=err0 cyc40", o.err, o.cycles); end
    checks++; if (o.data !== resp_func(insn, 32'h11, 32'h22)) begin errors++; $display("FAIL longwait_data got=%h want=%h", o.data, resp_func(insn, 32'h11, 32'h22)); end
    run_txn(insn, 32'h1, 32'h2, 0, 1, 2, 1'b1, 0, 0, o);
    checks++; if (o.err !== 1'b1 || o.cycles !== 16'(TB_LONG) || o.valid_cycles != TB_LONG) begin errors++; $display("FAIL long_timeout got=err%b cyc%0d valid%0d want=err1 cyc%0d", o.err, o.cycles, o.valid_cycles, TB_LONG); end
  endtask

  task automatic test_ready_boundary();
    obs_t o;
    run_txn(32'h0000_100B, 32'h5, 32'h6, TB_TIMEOUT, 1, 0, 1'b1, 0, 0, o);
    checks++; if (o.err !== 1'b0 || o.cycles !== 16'(TB_TIMEOUT)) begin errors++; $display("FAIL ready_at_limit got=err%b cyc%0d want=err0 cyc%0d", o.err, o.cycles, TB_TIMEOUT); end
    run_txn(32'h0000_100B, 32'h5, 32'h6, TB_TIMEOUT + 1, 1, 0, 1'b1, 0, 0, o);
    checks++; if (o.err !== 1'b1 || o.cycles !== 16'(TB_TIMEOUT)) begin errors++; $display("FAIL ready_past_limit got=err%b cyc%0d want=err1 cyc%0d", o.err, o.cycles, TB_TIMEOUT); end
  endtask

  task automatic test_dup_ready();
    obs_t o;
    int unsigned rises0;
    logic [31:0] insn;
    insn = make_rtype(FPADD, 5'd9, 5'd8, 5'd4);
    rises0 = rsp_rises;
    run_txn(insn, 32'hAAAA_0001, 32'h5555_0002, 5, 2, 0, 1'b0, 5, 0, o);
    repeat (6) @(negedge clk);
    checks++; if (rsp_rises != rises0 + 1) begin errors++; $display("FAIL dup_ready_count got=%0d want=1", rsp_rises - rises0); end
    checks++; if (o.unstable || o.cmdrdy_in_resp) begin errors++; $display("FAIL dup_ready_hold got=unstable%0d cmdrdy%0d want=0 0", o.unstable, o.cmdrdy_in_resp); end
    checks++; if (o.err !== 1'b0 || o.wr !== 1'b0 || o.data !== resp_func(insn, 32'hAAAA_0001, 32'h5555_0002)) begin errors++; $display("FAIL dup_ready_rsp got=%h wr%b err%b want=%h wr0 err0", o.data, o.wr, o.err, resp_func(insn, 32'hAAAA_0001, 32'h5555_0002)); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int unsigned oc0, gv0, rdy, wt, bad;
    logic [31:0] insn, a, b;
    logic        e_err;
    logic [15:0] e_cyc;
    oc0 = op_changes; gv0 = gap_viol; bad = 0;
    for (int unsigned t = 0; t < 6; t++) begin
      insn = $urandom; a = $urandom; b = $urandom;
      rdy = $urandom_range(1, 8); wt = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      run_txn(insn, a, b, rdy, 1, wt, 1'b1, 0, (t != 5), o);
      model(rdy, wt, e_err, e_cyc);
      if (!o.got_rsp || o.err !== e_err || o.cycles !== e_cyc || o.data !== resp_func(insn, a, b)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_responses got=%0d bad want=0", bad); end
    checks++; if (op_changes != oc0) begin errors++; $display("FAIL b2b_operand_stable got=%0d changes want=0", op_changes - oc0); end
    checks++; if (gap_viol != gv0) begin errors++; $display("FAIL b2b_gap got=%0d short gaps want=0", gap_viol - gv0); end
  endtask

  task automatic test_random();
    obs_t o;
    int unsigned rdy, wt;
    logic [31:0] insn, a, b, e_data;
    logic        e_err, e_wr, wr;
    logic [15:0] e_cyc;
    for (int unsigned t = 0; t < 20; t++) begin
      insn = $urandom; a = $urandom; b = $urandom; wr = 1'($urandom);
      rdy = $urandom_range(1, 30);
      wt  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
      run_txn(insn, a, b, rdy, 1, wt, wr, $urandom_range(0, 3), 0, o);
      model(rdy, wt, e_err, e_cyc);
      e_data = e_err ? 32'h0 : resp_func(insn, a, b);
      e_wr   = e_err ? 1'b0 : wr;
      checks++; if (!o.got_rsp || o.err !== e_err || o.cycles !== e_cyc) begin errors++; $display("FAIL rand%0d_status got=err%b cyc%0d want=err%b cyc%0d", t, o.err, o.cycles, e_err, e_cyc); end
      checks++; if (o.data !== e_data || o.wr !== e_wr) begin errors++; $display("FAIL rand%0d_data got=%h wr%b want=%h wr%b", t, o.data, o.wr, e_data, e_wr); end
      checks++; if (o.valid_cycles != 32'(e_cyc) || o.unstable) begin errors++; $display("FAIL rand%0d_bus got=valid%0d unstable%0d want=valid%0d", t, o.valid_cycles, o.unstable, e_cyc); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int unsigned n, rises0;
    logic [31:0] insn;
    r_rdy_at = 0; r_wait_at = 0;
    cmd_valid = 1'b1; cmd_insn = 32'h0BAD_F00D; cmd_rs1 = 32'h1; cmd_rs2 = 32'h2;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (pcpi_valid !== 1'b1) begin errors++; $display("FAIL rstmid_in_issue got=%b want=1", pcpi_valid); end
    rises0 = rsp_rises;
    #2 reset = 1'b1;
    #1;
    checks++; if (pcpi_valid !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_async got=pv%b rv%b cr%b want=0 0 0", pcpi_valid, rsp_valid, cmd_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b0 || pcpi_insn !== 32'h0) begin errors++; $display("FAIL rstmid_cleared got=cr%b insn%h want=0 0", cmd_ready, pcpi_insn); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready got=%b want=1", cmd_ready); end
    repeat (20) @(negedge clk);
    checks++; if (rsp_rises != rises0) begin errors++; $display("FAIL rstmid_no_rsp got=%0d want=0", rsp_rises - rises0); end
    insn = make_rtype(FPSUB, 5'd2, 5'd1, 5'd3);
    run_txn(insn, 32'h3F800000, 32'h40400000, 2, 1, 0, 1'b1, 0, 0, o);
    checks++; if (o.err !== 1'b0 || o.data !== 32'h40000000 || o.cycles !== 16'd2) begin errors++; $display("FAIL rstmid_after got=%h err%b cyc%0d want=40000000 err0 cyc2", o.data, o.err, o.cycles); end
  endtask

  initial begin
    test_reset();
    test_fpsub();
    test_no_responder();
    test_long_wait();
    test_ready_boundary();
    test_dup_ready();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/picorv32_pcpi_issuer.md
# picorv32_pcpi_issuer

PCPI initiator that drives the co-processor side of the PicoRV32 PCPI bus from a simple valid/ready command stream. It lets a dispatcher or test sequencer fire custom R-type instructions (FP add/sub/mul, etc.) at any `picorv32_pcpi_*` responder without a CPU core. It presents one outstanding transaction at a time, handles `pcpi_wait`, and applies a timeout. It returns result, write flag, error and latency on a valid/ready response stream.

## Interface
- `TIMEOUT`, 16 — cycles allowed from `pcpi_valid` rise to first `pcpi_wait`/`pcpi_ready` (PicoRV32 illegal-insn window).
- `LONG_TIMEOUT`, 1024 — total cycles allowed once `pcpi_wait` was seen.
- `GAP`, 1 — minimum idle cycles with `pcpi_valid`=0 between transactions (≥1).
- `clk` in 1 — clock.
- `reset` in 1 — asynchronous, active-high reset.
- `cmd_valid` in 1 — command offered.
- `cmd_ready` out 1 — issuer can accept.
- `cmd_insn` in 32 — instruction word.
- `cmd_rs1` in 32 — operand 1.
- `cmd_rs2` in 32 — operand 2.
- `pcpi_valid` out 1 — request to responder.
- `pcpi_insn` out 32 — held instruction.
- `pcpi_rs1` out 32 — held operand 1.
- `pcpi_rs2` out 32 — held operand 2.
- `pcpi_wait` in 1 — responder busy.
- `pcpi_ready` in 1 — responder done.
- `pcpi_wr` in 1 — result valid for writeback.
- `pcpi_rd` in 32 — result.
- `rsp_valid` out 1 — response available.
- `rsp_ready` in 1 — consumer accepts.
- `rsp_data` out 32 — captured `pcpi_rd` (0 on error).
- `rsp_wr` out 1 — captured `pcpi_wr` (0 on error).
- `rsp_err` out 1 — 1 = timeout.
- `rsp_cycles` out 16 — cycles from `pcpi_valid` rise to completion, inclusive, saturating at 16'hFFFF.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1 once the gap counter reaches 0. On `cmd_valid & cmd_ready`, latch insn/rs1/rs2 and go to ISSUE.
  - ISSUE: `pcpi_valid`=1; count cycles; set `seen_wait` when `pcpi_wait`=1.
    - `pcpi_ready`=1 → capture `pcpi_rd`, `pcpi_wr`, set err=0, go to RESP.
    - No `pcpi_ready`, with `!seen_wait && cnt==TIMEOUT` or `seen_wait && cnt==LONG_TIMEOUT` → err=1, data=0, wr=0, go to RESP.
  - RESP: `pcpi_valid`=0, `rsp_valid`=1. On `rsp_ready`, load gap counter with GAP and go to IDLE.
- `pcpi_insn/rs1/rs2` are stable for the whole of ISSUE. They keep their last value outside ISSUE and are never combinationally fed from `cmd_*`.
- `pcpi_ready` outside ISSUE is ignored, covering a late or duplicate ready from a responder still in its output state.
- `pcpi_ready` and timeout in the same cycle: ready wins, err=0.
- `pcpi_wr`=0 with `pcpi_ready`=1 is a legal, non-error completion.
- Cycle counter: 16-bit saturating. Reset to 1 on ISSUE entry and incremented each ISSUE cycle.
- Reset mid-transaction:
  - All state cleared, FSM to IDLE, gap counter cleared.
  - `pcpi_valid` drops asynchronously.
  - The in-flight response is discarded and no `rsp_valid` is produced.

## Timing
- Reset values:
  - `cmd_ready`=0, `pcpi_valid`=0, `rsp_valid`=0.
  - `pcpi_insn/rs1/rs2`=0, `rsp_data`=0, `rsp_wr`=0, `rsp_err`=0, `rsp_cycles`=0.
  - `cmd_ready` rises the first cycle after reset release.
- Accept at edge N → `pcpi_valid`=1 from N+1.
- `pcpi_ready` sampled at edge M → `pcpi_valid`=0 and `rsp_valid`=1 from M+1.
- Response accept at edge K → `cmd_ready`=1 again from K+1+GAP.
- Minimum round trip is 3 cycles plus responder latency. Throughput is one transaction per (latency+2+GAP) cycles.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Shared package `pcpi_pkg`:
  - state enum `{IDLE, ISSUE, RESP}`.
  - opcode constant `PCPI_CUSTOM0 = 7'b0001011`.
  - funct7 constants `FPADD`, `FPSUB = 7'b0000010`, `FPMUL`, etc.
  - default `TIMEOUT`/`LONG_TIMEOUT`.
- One natural sub-module, `pcpi_sat_counter`: parameterized-width saturating counter with load/enable, used for the cycle counter and the gap counter.

## Test plan
- FPSUB, insn funct7=0000010, opcode=0001011, rs1=0x40000000 (2.0), rs2=0x40400000 (3.0), paired with the fpsub responder (computes rs2 − rs1):
  - → `rsp_data`=0x3F800000 (1.0), `rsp_wr`=1, `rsp_err`=0, `rsp_cycles` matches the FSM length.
- No responder (`pcpi_wait`=`pcpi_ready`=0):
  - → `rsp_valid` after exactly 16 ISSUE cycles, `rsp_err`=1, `rsp_data`=0, `rsp_cycles`=16.
- Responder asserts `pcpi_wait` at cycle 3 and `pcpi_ready` at cycle 40:
  - → no timeout, `rsp_err`=0, `rsp_cycles`=40.
- `pcpi_ready` pulsed 2 consecutive cycles:
  - → exactly one response.
  - `rsp_ready` held 0 for 5 cycles → `rsp_valid`, `rsp_data` stable, `cmd_ready`=0 throughout.
- Back-to-back commands with `cmd_valid` always 1, GAP=1:
  - → `pcpi_valid` low ≥1 cycle between transactions.
  - Operands never change while `pcpi_valid`=1.
- `reset` asserted mid-ISSUE:
  - → `pcpi_valid`=0 immediately, no `rsp_valid`.
  - After release, `cmd_ready`=1 next cycle and a new command completes normally.
